multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports `clk` and `reset`.
REQ-002 SHALL have ports, as name direction width meaning:
- clk  in  1  clock, rising edge.
- reset  in  1  async active-high reset.
- opcode  in  7  IR[6:0]; stable from ID onward.
- bcond  in  1  ALU branch-compare result, valid in EX.
- mem_ready  in  1  memory completes the access this cycle.
- halt_req  in  1  ECALL halt condition (x17==10), valid in ID.
- mem_read, mem_write  out  1  memory strobes.
- i_or_d  out  1  0=PC address, 1=ALUOut address.
- ir_write  out  1  IR and old_pc load.
- pc_write  out  1  PC <= ALU result.
- reg_write  out  1  register-file write.
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4.
- alu_op  out  2  00 ADD, 01 BRANCH, 10 FUNCT, 11 FUNCT_IMM.
- is_halted  out  1  processor stopped.
- retired_count  out  32  instructions completed.

Function
REQ-003 SHALL implement states IF, ID, EX, MEM, WB, BR, HALT.
REQ-004 All strobes SHALL be decoded from state, opcode, bcond and mem_ready; unlisted outputs SHALL be 0.
REQ-005 In IF: mem_read=1, i_or_d=0, ALU computes PC+4 (src_a=00, src_b=10, ADD).
  - On mem_ready=1: ir_write=1, pc_write=1, go to ID.
  - Otherwise: hold IF with no write strobes.
REQ-006 In ID: no strobes; transitions by opcode:
  - ECALL with halt_req=1 -> HALT.
  - ECALL with halt_req=0 -> IF, instruction retired.
  - Undefined opcode -> IF, retired as NOP.
  - Any other opcode -> EX.
REQ-007 In EX, per opcode:
  - ARITHMETIC: src 10/00, FUNCT -> WB.
  - ARITHMETIC_IMM: src 10/01, FUNCT_IMM -> WB.
  - LOAD or STORE: src 10/01, ADD -> MEM.
  - BRANCH: src 10/00, BRANCH; bcond=0 -> IF, retired; bcond=1 -> BR.
  - JAL: src 01/01, ADD, pc_write=1, reg_write=1, wb_sel=10 -> IF, retired.
  - JALR: as JAL but src_a=10; clearing the target LSB is done in the datapath.
REQ-008 In MEM: i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE; hold until mem_ready=1.
  - On mem_ready=1: LOAD -> WB; STORE -> IF, retired.
REQ-009 In WB: reg_write=1, wb_sel=01 for LOAD else 00 -> IF, retired.
REQ-010 In BR: src 01/01, ADD, pc_write=1 -> IF, retired.
REQ-011 HALT SHALL be absorbing until reset; is_halted=1 there; no strobes.
REQ-012 With mem_ready=1, latencies in cycles SHALL be:
  - R/I-type 4, load 5, store 4.
  - Branch not-taken 3, taken 4.
  - JAL/JALR 3, ECALL 2.
REQ-013 retired_count SHALL increment by exactly 1 on each retiring transition.
  - It wraps 0xFFFFFFFF -> 0.
  - The halting ECALL is not counted.

Reset
REQ-014 While reset=1, state SHALL be IF, retired_count SHALL be 0, and every output SHALL be 0, including mem_read.
REQ-015 Reset asserted in any state, including HALT or a mid-MEM wait, SHALL abort the instruction with no further write strobes.
  - The first cycle after deassertion is IF.

Structure
REQ-016 State encodings (3 bits) and the alu_op, alu_src_a/b and wb_sel codes SHALL live in a shared header alongside the existing opcode constants.
REQ-017 Output decoding SHALL be one combinational sub-module, mc_ctrl_decode.
  - Inputs: state, opcode, bcond, mem_ready.
  - The parent holds the state register and retired_count.

Verification
REQ-018 R-type (opcode 0110011), mem_ready=1 -> states IF,ID,EX,WB; one pc_write in IF, reg_write in WB only; retired_count 0->1.
REQ-019 LOAD with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_read=1, i_or_d=1 throughout, no reg_write until WB; total 8 cycles.
REQ-020 BRANCH with bcond=0 -> IF,ID,EX,IF; with bcond=1 -> BR with pc_write=1, src_a=01; retired_count +1 each.
REQ-021 ECALL with halt_req=1 -> HALT after 2 cycles, is_halted=1 held 100 cycles, retired_count unchanged; reset -> IF, is_halted=0.
REQ-022 retired_count preset via 2^32-1 retirements (or forced) -> next retirement yields 0.
REQ-023 Reset pulsed mid-MEM of a STORE -> mem_write drops to 0 immediately (async); restart in IF with count 0.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: instruction opcodes, FSM state codes
// and the datapath select codes driven by the strobe decoder.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OpLoad     = 7'b0000011;
    localparam logic [6:0] OpArithImm = 7'b0010011;
    localparam logic [6:0] OpStore    = 7'b0100011;
    localparam logic [6:0] OpArith    = 7'b0110011;
    localparam logic [6:0] OpBranch   = 7'b1100011;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [6:0] OpJal      = 7'b1101111;
    localparam logic [6:0] OpEcall    = 7'b1110011;

    localparam logic [2:0] StIf   = 3'd0;
    localparam logic [2:0] StId   = 3'd1;
    localparam logic [2:0] StEx   = 3'd2;
    localparam logic [2:0] StMem  = 3'd3;
    localparam logic [2:0] StWb   = 3'd4;
    localparam logic [2:0] StBr   = 3'd5;
    localparam logic [2:0] StHalt = 3'd6;

    localparam logic [1:0] AluAdd      = 2'b00;
    localparam logic [1:0] AluBranch   = 2'b01;
    localparam logic [1:0] AluFunct    = 2'b10;
    localparam logic [1:0] AluFunctImm = 2'b11;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    localparam logic [1:0] WbAluOut = 2'b00;
    localparam logic [1:0] WbMdr    = 2'b01;
    localparam logic [1:0] WbPc     = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_known_op(input logic [6:0] op);
        return op inside {OpLoad, OpArithImm, OpStore, OpArith, OpBranch, OpJalr, OpJal, OpEcall};
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational strobe decoder: maps FSM state, opcode, bcond and mem_ready to datapath
// controls. Holds no state.
module mc_ctrl_decode
    import multicycle_control_unit_pkg::*;
(
    input  logic [2:0] state,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output logic       take_branch
);

    assign take_branch = (state == StEx) && (opcode == OpBranch) && bcond;

    always_comb begin
        ctrl = '0;
        case (state)
            StIf: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SrcAPc;
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_op    = AluAdd;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            StEx: begin
                case (opcode)
                    OpArith: begin
                        ctrl.alu_src_a = SrcARs1;
                        ctrl.alu_src_b = SrcBRs2;
                        ctrl.alu_op    = AluFunct;
                    end
                    OpArithImm: begin
                        ctrl.alu_src_a = SrcARs1;
                        ctrl.alu_src_b = SrcBImm;
                        ctrl.alu_op    = AluFunctImm;
                    end
                    OpLoad, OpStore: begin
                        ctrl.alu_src_a = SrcARs1;
                        ctrl.alu_src_b = SrcBImm;
                        ctrl.alu_op    = AluAdd;
                    end
                    OpBranch: begin
                        ctrl.alu_src_a = SrcARs1;
                        ctrl.alu_src_b = SrcBRs2;
                        ctrl.alu_op    = AluBranch;
                    end
                    OpJal, OpJalr: begin
                        // JALR's target LSB is cleared downstream in the datapath
                        ctrl.alu_src_a = (opcode == OpJal) ? SrcAOldPc : SrcARs1;
                        ctrl.alu_src_b = SrcBImm;
                        ctrl.alu_op    = AluAdd;
                        ctrl.pc_write  = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_sel    = WbPc;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = (opcode == OpLoad);
                ctrl.mem_write = (opcode == OpStore);
            end
            StWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = (opcode == OpLoad) ? WbMdr : WbAluOut;
            end
            StBr: begin
                ctrl.alu_src_a = SrcAOldPc;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluAdd;
                ctrl.pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM: owns the state register and retired-instruction counter;
// strobes come from mc_ctrl_decode and are forced low while reset is asserted.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        is_halted,
    output logic [31:0] retired_count
);

    logic [2:0]  state_q, state_d;
    logic [31:0] retired_count_q;
    logic        retire;
    logic        take_branch;
    ctrl_t       ctrl, ctrl_out;

    mc_ctrl_decode u_decode (
        .state       (state_q),
        .opcode      (opcode),
        .bcond       (bcond),
        .mem_ready   (mem_ready),
        .ctrl        (ctrl),
        .take_branch (take_branch)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StIf: if (mem_ready) state_d = StId;
            StId: begin
                if (opcode == OpEcall && halt_req) begin
                    state_d = StHalt;
                end else if (opcode == OpEcall || !is_known_op(opcode)) begin
                    state_d = StIf;
                    retire  = 1'b1;
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                case (opcode)
                    OpArith, OpArithImm: state_d = StWb;
                    OpLoad, OpStore:     state_d = StMem;
                    OpBranch: begin
                        state_d = take_branch ? StBr : StIf;
                        retire  = !take_branch;
                    end
                    OpJal, OpJalr: begin
                        state_d = StIf;
                        retire  = 1'b1;
                    end
                    default: state_d = StIf;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (opcode == OpLoad) ? StWb : StIf;
                    retire  = (opcode != OpLoad);
                end
            end
            StWb, StBr: begin
                state_d = StIf;
                retire  = 1'b1;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIf;
            retired_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_count_q <= retired_count_q + 32'd1;
        end
    end

    // IF drives mem_read even idle, so gate on reset to keep every output low while held
    assign ctrl_out      = reset ? '0 : ctrl;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign i_or_d        = ctrl_out.i_or_d;
    assign ir_write      = ctrl_out.ir_write;
    assign pc_write      = ctrl_out.pc_write;
    assign reg_write     = ctrl_out.reg_write;
    assign wb_sel        = ctrl_out.wb_sel;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign is_halted     = (state_q == StHalt) && !reset;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: builds each instruction's expected per-cycle strobe script from its
// class, applies directed table vectors, corner sequences and random instructions.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        bcond = 1'b0;
    logic        mem_ready = 1'b0;
    logic        halt_req = 1'b0;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, is_halted;
    logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;
    logic [31:0] retired_count;

    multicycle_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .bcond         (bcond),
        .mem_ready     (mem_ready),
        .halt_req      (halt_req),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .is_halted     (is_halted),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, ECALL = 7'b1110011, UNDEF = 7'b1111111;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] model_count = 32'd0;

    typedef struct { logic mr; logic [14:0] exp; } step_t;
    step_t script[$];

    typedef struct {
        string      name;
        logic [6:0] op;
        logic       bc;
        logic       hr;
        int         ifw;
        int         memw;
        int         delta;
    } vec_t;
    vec_t vecs[13];

    // {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, wb, src_a, src_b, alu, halted}
    function automatic logic [14:0] o(input bit mr, input bit mw, input bit iod, input bit irw,
                                      input bit pcw, input bit rw, input logic [1:0] wb,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] op, input bit h);
        return {mr, mw, iod, irw, pcw, rw, wb, sa, sb, op, h};
    endfunction

    function automatic logic [14:0] actual();
        return {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, wb_sel, alu_src_a,
                alu_src_b, alu_op, is_halted};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic mr, input logic [14:0] exp);
        step_t s;
        s.mr  = mr;
        s.exp = exp;
        script.push_back(s);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from its class alone
    task automatic build(input logic [6:0] op, input logic bc, input logic hr, input int ifw,
                         input int memw, output int retire);
        script.delete();
        retire = 1;
        for (int i = 0; i < ifw; i++) push(1'b0, o(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        push(1'b1, o(1, 0, 0, 1, 1, 0, 0, 0, 2, 0, 0));
        push(1'($urandom_range(1)), '0);
        case (op)
            ECALL: if (hr) retire = 0;
            R_OP: begin
                push(1'($urandom_range(1)), o(0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0));
                push(1'($urandom_range(1)), o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            end
            I_OP: begin
                push(1'($urandom_range(1)), o(0, 0, 0, 0, 0, 0, 0, 2, 1, 3, 0));
                push(1'($urandom_range(1)), o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            end
            LD: begin
                push(1'($urandom_range(1)), o(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
                for (int i = 0; i <= memw; i++)
                    push(i == memw, o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                push(1'($urandom_range(1)), o(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
            end
            ST: begin
                push(1'($urandom_range(1)), o(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
                for (int i = 0; i <= memw; i++)
                    push(i == memw, o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            BR: begin
                push(1'($urandom_range(1)), o(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
                if (bc) push(1'($urandom_range(1)), o(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
            end
            JAL:  push(1'($urandom_range(1)), o(0, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0));
            JALR: push(1'($urandom_range(1)), o(0, 0, 0, 0, 1, 1, 2, 2, 1, 0, 0));
            default: ;
        endcase
    endtask

    // Entered at posedge+1; leaves at posedge+1 of the cycle after the last applied step
    task automatic apply(input string tag, input int upto);
        foreach (script[i]) begin
            if (i < upto) begin
                mem_ready = script[i].mr;
                #1;
                check($sformatf("%s c%0d", tag, i), 32'(actual()), 32'(script[i].exp));
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic bc,
                             input logic hr, input int ifw, input int memw, input int delta);
        int retire;
        opcode   = op;
        bcond    = bc;
        halt_req = hr;
        build(op, bc, hr, ifw, memw, retire);
        apply(name, 1000);
        model_count += 32'((delta < 0) ? retire : delta);
        check({name, " count"}, retired_count, model_count);
    endtask

    initial begin
        logic [6:0] ops[9];
        ops = '{R_OP, I_OP, LD, ST, BR, JAL, JALR, ECALL, UNDEF};
        vecs = '{
            '{"rtype",      R_OP,  1'b0, 1'b0, 0, 0, 1},
            '{"itype",      I_OP,  1'b0, 1'b1, 0, 0, 1},
            '{"load",       LD,    1'b0, 1'b0, 0, 0, 1},
            '{"load_wait3", LD,    1'b1, 1'b0, 0, 3, 1},
            '{"store",      ST,    1'b0, 1'b0, 0, 0, 1},
            '{"store_wait", ST,    1'b0, 1'b0, 1, 2, 1},
            '{"br_nt",      BR,    1'b0, 1'b0, 0, 0, 1},
            '{"br_t",       BR,    1'b1, 1'b0, 0, 0, 1},
            '{"jal",        JAL,   1'b1, 1'b0, 0, 0, 1},
            '{"jalr",       JALR,  1'b0, 1'b0, 0, 0, 1},
            '{"ecall",      ECALL, 1'b0, 1'b0, 0, 0, 1},
            '{"undef",      UNDEF, 1'b0, 1'b1, 0, 0, 1},
            '{"rtype_ifw2", R_OP,  1'b0, 1'b0, 2, 0, 1}
        };

        // Held in reset: everything low, even with mem_ready asserted
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 32'(actual()), 32'd0);
        check("reset count", retired_count, 32'd0);
        reset = 1'b0;

        foreach (vecs[i])
            run_instr(vecs[i].name, vecs[i].op, vecs[i].bc, vecs[i].hr, vecs[i].ifw,
                      vecs[i].memw, vecs[i].delta);

        // Counter wrap: preload all-ones while idling in IF
        mem_ready = 1'b0;
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        model_count = 32'hFFFF_FFFF;
        check("wrap preload", retired_count, model_count);
        run_instr("wrap", R_OP, 1'b0, 1'b0, 0, 0, -1);

        // Reset in the middle of a store's memory wait
        opcode   = ST;
        bcond    = 1'b0;
        halt_req = 1'b0;
        begin
            int r;
            build(ST, 1'b0, 1'b0, 0, 5, r);
        end
        apply("st_abort", 5);
        mem_ready = 1'b0;
        #1;
        check("st_abort mem_write before", 32'(mem_write), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("st_abort outputs", 32'(actual()), 32'd0);
        check("st_abort count", retired_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_count = 32'd0;
        run_instr("after_abort", R_OP, 1'b0, 1'b0, 0, 0, -1);

        // Halting ECALL absorbs for 100 cycles, then reset recovers
        run_instr("halt", ECALL, 1'b0, 1'b1, 0, 0, -1);
        for (int i = 0; i < 100; i++) begin
            mem_ready = 1'($urandom_range(1));
            opcode    = 7'($urandom);
            #1;
            if (i % 20 == 0 || i == 99) begin
                check($sformatf("halt c%0d", i), 32'(actual()), 32'(o(0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 1)));
                check($sformatf("halt count c%0d", i), retired_count, model_count);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("halt reset is_halted", 32'(is_halted), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_count = 32'd0;
        check("halt reset count", retired_count, 32'd0);
        run_instr("after_halt", JAL, 1'b0, 1'b0, 0, 0, -1);

        // Random instruction stream against the class-level model
        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            logic       hr;
            op = ops[$urandom_range(7)];
            if (n % 9 == 8) op = UNDEF;
            hr = (op == ECALL) ? 1'b0 : 1'($urandom_range(1));
            run_instr($sformatf("rnd%0d", n), op, 1'($urandom_range(1)), hr,
                      $urandom_range(2), $urandom_range(3), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
